// File: rtl/branch_stats_reporter_if.sv
// Byte-stream handshake between the statistics reporter and its sink (UART TX or trace FIFO).
interface branch_stats_reporter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/branch_stats_reporter.sv
// Snapshots the branch-predictor counters and sends them as a checksummed byte frame.
// Optional macro STATS_FRAME_SEQ_EN inserts an 8-bit frame sequence number after the header.
module branch_stats_reporter #(
    parameter logic [7:0]  HEADER_BYTE  = 8'hA5,
    parameter int unsigned AUTO_PERIOD  = 0,
    parameter int unsigned PERIOD_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [31:0]                    total_branches,
    input  logic [31:0]                    correct_sbp,
    input  logic [31:0]                    correct_dbp,
    branch_stats_reporter_if.master        tx,
    output logic                           busy,
    output logic                           done
);
`ifdef STATS_FRAME_SEQ_EN
    typedef enum logic [2:0] {IDLE, HEADER, SEQ, PAYLOAD, CHECKSUM} state_t;
`else
    typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, CHECKSUM} state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [95:0] snap;
    logic [3:0]  idx;
    logic [7:0]  csum;
    logic [7:0]  byte_out;
    logic        auto_fire;
    logic        trigger;
    logic        accept;
`ifdef STATS_FRAME_SEQ_EN
    logic [7:0]  seq;
`endif

    generate
        if (AUTO_PERIOD > 0) begin : g_auto
            localparam logic [PERIOD_WIDTH-1:0] LAST = PERIOD_WIDTH'(AUTO_PERIOD - 1);
            logic [PERIOD_WIDTH-1:0] auto_cnt;

            always_ff @(posedge clk) begin
                if (reset)
                    auto_cnt <= '0;
                else if (auto_cnt == LAST)
                    auto_cnt <= '0;
                else
                    auto_cnt <= auto_cnt + PERIOD_WIDTH'(1);
            end

            assign auto_fire = (auto_cnt == LAST);
        end else begin : g_no_auto
            assign auto_fire = 1'b0;
        end
    endgenerate

    assign trigger = start || auto_fire;
    assign accept  = tx.tx_valid && tx.tx_ready;

    always_comb begin
        byte_out = 8'h00;
        case (state)
            HEADER:   byte_out = HEADER_BYTE;
`ifdef STATS_FRAME_SEQ_EN
            SEQ:      byte_out = seq;
`endif
            PAYLOAD:  byte_out = snap[{idx, 3'b000} +: 8];
            CHECKSUM: byte_out = csum;
            default:  byte_out = 8'h00;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (trigger) state_nxt = HEADER;
`ifdef STATS_FRAME_SEQ_EN
            HEADER:   if (accept) state_nxt = SEQ;
            SEQ:      if (accept) state_nxt = PAYLOAD;
`else
            HEADER:   if (accept) state_nxt = PAYLOAD;
`endif
            PAYLOAD:  if (accept && idx == 4'd11) state_nxt = CHECKSUM;
            CHECKSUM: if (accept) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            snap  <= '0;
            idx   <= '0;
            csum  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == CHECKSUM) && accept;
            // All three counters are captured on the same edge so the frame is coherent.
            if (state == IDLE && trigger) begin
                snap <= {correct_dbp, correct_sbp, total_branches};
                csum <= '0;
                idx  <= '0;
            end else if (accept && state != CHECKSUM) begin
                csum <= csum + byte_out;
            end
            if (state == PAYLOAD && accept)
                idx <= idx + 4'd1;
        end
    end

`ifdef STATS_FRAME_SEQ_EN
    always_ff @(posedge clk) begin
        if (reset)
            seq <= '0;
        else if (state == CHECKSUM && accept)
            seq <= seq + 8'd1;
    end
`endif

    assign tx.tx_valid = (state != IDLE);
    assign tx.tx_data  = byte_out;
    assign busy        = (state != IDLE);
endmodule

// File: tb/tb_branch_stats_reporter.sv
// Bench for branch_stats_reporter: queue-based frame model, directed frame checks, random traffic.
module tb_branch_stats_reporter;
    localparam int AP = 20;
`ifdef STATS_FRAME_SEQ_EN
    localparam int FLEN = 15;
`else
    localparam int FLEN = 14;
`endif

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] tot = '0;
    logic [31:0] sbp = '0;
    logic [31:0] dbp = '0;
    logic        busy;
    logic        done;

    branch_stats_reporter_if bus();

    branch_stats_reporter #(
        .HEADER_BYTE (8'hA5),
        .AUTO_PERIOD (AP),
        .PERIOD_WIDTH(32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .total_branches(tot),
        .correct_sbp   (sbp),
        .correct_dbp   (dbp),
        .tx            (bus),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a queue of the bytes still owed by the current frame.
    bq_t        mq;
    logic       m_done = 1'b0;
    int         m_cnt = 0;
    logic [7:0] m_seq = 8'h00;
    bit         m_ok = 1'b0;

    function automatic bq_t frame_of(logic [31:0] t, logic [31:0] s, logic [31:0] d);
        bq_t         q;
        int          sum;
        logic [31:0] w[3];
        w = '{t, s, d};
        q.push_back(8'hA5);
`ifdef STATS_FRAME_SEQ_EN
        q.push_back(m_seq);
`endif
        for (int i = 0; i < 3; i++)
            for (int k = 0; k < 4; k++)
                q.push_back(8'((w[i] >> (8 * k)) & 32'hFF));
        sum = 0;
        foreach (q[i]) sum += int'(q[i]);
        q.push_back(8'(sum % 256));
        return q;
    endfunction

    always @(posedge clk) begin
        bit fire;
        cyc++;
        if (reset) begin
            mq.delete();
            m_done = 1'b0;
            m_cnt  = 0;
            m_seq  = 8'h00;
            m_ok   = 1'b1;
        end else begin
            fire   = (m_cnt == AP - 1);
            m_cnt  = fire ? 0 : m_cnt + 1;
            m_done = 1'b0;
            if (mq.size() == 0) begin
                if (start || fire) mq = frame_of(tot, sbp, dbp);
            end else if (bus.tx_ready) begin
                void'(mq.pop_front());
                if (mq.size() == 0) begin
                    m_done = 1'b1;
                    m_seq  = m_seq + 8'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("tx_valid", bus.tx_valid, mq.size() != 0);
            chk("busy", busy, mq.size() != 0);
            chk("done", done, m_done);
            if (mq.size() != 0) chk("tx_data", bus.tx_data, mq[0]);
        end
    end

    // Observed traffic for the directed checks.
    bq_t  cap;
    int   hcyc[$];
    int   starts[$];
    int   dones[$];
    logic prev_valid = 1'b0;

    always @(negedge clk) begin
        if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
            cap.push_back(bus.tx_data);
            hcyc.push_back(cyc);
        end
        if (bus.tx_valid === 1'b1 && prev_valid !== 1'b1) starts.push_back(cyc);
        if (done === 1'b1) dones.push_back(cyc);
        prev_valid = bus.tx_valid;
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        tick(2);
        reset = 1'b0;
        cap.delete();
        hcyc.delete();
        starts.delete();
        dones.delete();
    endtask

    task automatic check_frame(string tag, bq_t exp);
`ifdef STATS_FRAME_SEQ_EN
        exp.insert(1, 8'h00);
`endif
        chk({tag, "_len"}, (cap.size() >= exp.size()) ? exp.size() : cap.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk({tag, "_byte"}, (i < cap.size()) ? {24'h0, cap[i]} : 32'hFFFF, exp[i]);
    endtask

    initial begin
        int  n0;
        bq_t exp;
        bus.tx_ready = 1'b1;

        // Reset state and basic frame
        do_reset();
        chk("rst_tx_valid", bus.tx_valid, 1'b0);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        n0 = cyc;
        tot = 32'h10; sbp = 32'hC; dbp = 32'hE;
        start = 1'b1; tick(); start = 1'b0;
        tick(16);
        exp = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00,
                8'h0E, 8'h00, 8'h00, 8'h00, 8'hCF};
        check_frame("basic", exp);
        chk("basic_hdr_cycle", starts[0], n0 + 1);
        chk("basic_done_cycle", dones[0], n0 + FLEN + 1);

        // Backpressure with ready pattern 1,0,0 from the header cycle
        do_reset();
        n0 = cyc;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i < 200 && dones.size() == 0; i++) begin
            bus.tx_ready = ((i % 3) == 1);
            tick();
        end
        bus.tx_ready = 1'b1;
        chk("bp_done_count", dones.size(), 1);
        check_frame("bp", exp);
        chk("bp_done_after_last", dones[0], hcyc[FLEN-1] + 1);

        // Snapshot coherency: inputs change the cycle after the trigger
        do_reset();
        tot = 32'h11223344; sbp = '0; dbp = '0;
        start = 1'b1; tick(); start = 1'b0;
        tot = '1; sbp = '1; dbp = '1;
        tick(16);
        exp = '{8'hA5, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h4F};
        check_frame("snap", exp);

        // Start while busy is ignored; start on the done cycle is accepted
        do_reset();
        n0 = cyc;
        tot = 32'h1234; sbp = 32'h55; dbp = 32'h77;
        start = 1'b1; tick(); start = 1'b0;
        while (cyc < n0 + 5) tick();
        start = 1'b1; tick(); start = 1'b0;
        while (cyc < n0 + FLEN + 1) tick();
        start = 1'b1; tick(); start = 1'b0;
        tick(FLEN + 2);
        chk("busy_starts", starts.size(), 2);
        chk("busy_first_hdr", starts[0], n0 + 1);
        chk("busy_second_hdr", starts[1], n0 + FLEN + 2);
        chk("busy_dones", dones.size(), 2);

        // Reset mid-frame aborts without done; next frame is complete
        do_reset();
        n0 = cyc;
        tot = 32'h10; sbp = 32'hC; dbp = 32'hE;
        start = 1'b1; tick(); start = 1'b0;
        while (cyc < n0 + 6) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("abort_tx_valid", bus.tx_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        cap.delete(); dones.delete(); starts.delete(); hcyc.delete();
        n0 = cyc;
        start = 1'b1; tick(); start = 1'b0;
        tick(16);
        exp = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00,
                8'h0E, 8'h00, 8'h00, 8'h00, 8'hCF};
        check_frame("after_abort", exp);
        chk("after_abort_dones", dones.size(), 1);
        chk("after_abort_done_cycle", dones[0], n0 + FLEN + 1);

        // Auto-trigger period
        do_reset();
        n0 = cyc;
        tick(70);
        chk("auto_count", starts.size() >= 3, 1'b1);
        chk("auto_first_hdr", starts[0], n0 + AP);
        chk("auto_period_1", starts[1] - starts[0], AP);
        chk("auto_period_2", starts[2] - starts[1], AP);

        // Auto-trigger while stalled produces no extra frame
        do_reset();
        bus.tx_ready = 1'b0;
        tick(60);
        chk("auto_stall_starts", starts.size(), 1);
        bus.tx_ready = 1'b1;
        tick(16);
        chk("auto_stall_starts_after", starts.size(), 1);
        chk("auto_stall_dones", dones.size(), 1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start        = ($urandom_range(0, 9) == 0);
            bus.tx_ready = ($urandom_range(0, 3) != 0);
            reset        = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 2) == 0) begin
                tot = $urandom;
                sbp = $urandom;
                dbp = $urandom;
            end
            tick();
        end
        reset = 1'b0;
        start = 1'b0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_stats_reporter.md
Name: branch_stats_reporter

Overview:
- Reads the branch-predictor statistics counters (total branches, static-predictor correct, dynamic-predictor correct) and serialises them as a byte-stream frame for a debug/host link (UART TX or trace FIFO).
- Accepts the counters as 32-bit inputs and snapshots them atomically on a trigger.
- Emits a framed, checksummed byte sequence over a valid/ready handshake.
- Triggered by a request pulse or by an optional periodic auto-trigger.

Parameters:
- HEADER_BYTE, 8'hA5, first byte of every frame.
- AUTO_PERIOD, 0, cycles between automatic reports; 0 disables auto-trigger.
- PERIOD_WIDTH, 32, width of the auto-trigger cycle counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  report request; sampled every cycle.
- total_branches  input  32  total branch instruction count.
- correct_sbp  input  32  static-predictor correct count.
- correct_dbp  input  32  dynamic-predictor correct count.
- tx_data  output  8  current frame byte.
- tx_valid  output  1  tx_data is valid.
- tx_ready  input  1  sink accepts the byte this cycle when tx_valid && tx_ready.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse after the final byte handshake.

Behaviour:
- Reset values: tx_valid=0, tx_data=8'h00, busy=0, done=0, FSM=IDLE, auto counter=0, checksum accumulator=0, snapshot registers=0. Reset wins over every other event in the same cycle.
- FSM states: IDLE, HEADER, PAYLOAD, CHECKSUM.
- IDLE -> HEADER on trigger. Trigger = start || auto_fire.
- Snapshot: in the trigger cycle, total_branches, correct_sbp and correct_dbp are registered together, so the frame is coherent even while the counters keep changing.
- Latency: trigger in cycle N gives tx_valid=1, tx_data=HEADER_BYTE, busy=1 in cycle N+1.
- Frame order: HEADER_BYTE, then total_branches, correct_sbp, correct_dbp, each little-endian (byte 0 first), then the checksum byte. 14 bytes total.
- Byte index: a 4-bit counter (0..11) walks the payload. PAYLOAD -> CHECKSUM after index 11 is accepted. CHECKSUM -> IDLE when the checksum is accepted.
- Checksum: sum modulo 256 of the header and all 12 payload bytes, accumulated as each byte is accepted.
- Handshake:
  - A byte advances only on tx_valid && tx_ready.
  - While tx_valid && !tx_ready, tx_data and tx_valid hold stable.
  - tx_valid stays high continuously within a frame; there are no bubbles when tx_ready is held high.
  - With tx_ready=1 throughout, bytes transfer in cycles N+1..N+14.
- Completion: the cycle after the final handshake has done=1, busy=0, tx_valid=0. A trigger in that cycle is accepted (FSM is IDLE), so back-to-back frames have a single idle cycle between them.
- start while busy is ignored (not queued).
- Auto-trigger (AUTO_PERIOD>0):
  - Counter increments every cycle.
  - When it reaches AUTO_PERIOD-1 it wraps to 0 and asserts auto_fire for one cycle.
  - If busy at that moment, the auto_fire is dropped.
  - start and auto_fire in the same cycle produce one frame.
  - Counter wrap is modulo 2**PERIOD_WIDTH if AUTO_PERIOD exceeds that range (not recommended).
- Reset mid-frame: frame is aborted; next cycle tx_valid=0, busy=0, done=0; no partial checksum is emitted.
- Input counter changes during a frame do not affect the bytes being sent.

Optional Feature:
- Macro: STATS_FRAME_SEQ_EN.
- Defined:
  - An 8-bit frame sequence number is inserted after HEADER_BYTE, giving a 15-byte frame.
  - The sequence number is included in the checksum.
  - It increments modulo 256 after each completed frame (on done), resets to 0, and is not incremented by aborted frames.
  - Completion occurs at N+16.
- Not defined: 14-byte frame as above, and no sequence register exists.

Test Plan:
- Basic frame: reset, total=32'h10, sbp=32'hC, dbp=32'hE, start pulse at N, tx_ready=1 -> bytes A5,10,00,00,00,0C,00,00,00,0E,00,00,00,CF in cycles N+1..N+14; done=1 at N+15; busy=0 at N+15.
- Backpressure: same inputs, tx_ready toggling 1,0,0,1,... -> identical byte sequence; tx_data stable on every stalled cycle; done only after the 14th handshake.
- Snapshot coherency: start with total=32'h11223344; change all inputs to 32'hFFFFFFFF at N+1 -> payload still 44,33,22,11,...; checksum matches the original values.
- Start while busy: second start at N+5 -> ignored, exactly one frame. Start at N+15 -> second frame begins with header at N+16.
- Reset mid-frame: reset asserted at N+6 -> tx_valid=0, busy=0 at N+7; no done pulse. A new start afterwards produces a full correct frame.
- Auto-trigger: AUTO_PERIOD=20, tx_ready=1, start=0 -> frame headers appear every 20 cycles; with tx_ready=0 stalling, auto_fire while busy produces no extra frame.
